// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring-division step
// per cycle, fixed latency from acceptance to result for every op and operand.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } op_e;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;

  state_e           state_q, state_d;
  op_e              op_q, op_in;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] opnd_q;   // multiplicand or divisor magnitude
  logic [WIDTH-1:0] acc_q;    // product high half or partial remainder
  logic [WIDTH-1:0] lo_q;     // product low half/multiplier or quotient/dividend
  logic [WIDTH-1:0] result_q;
  logic [CNT_W-1:0] count_q;

  logic             accept, a_signed, b_signed, is_div_in, is_div_q;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum, div_shift;
  logic [WIDTH-1:0] div_diff, acc_d, lo_d;
  logic             div_ge;
  logic             a_neg, b_neg, b_zero, sgn_ovf;
  logic [WIDTH-1:0] hi_neg, quo_neg, rem_neg, fix_result;

  assign op_in     = op_e'(op);
  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign result    = result_q;
  assign accept    = in_ready && in_valid && !flush;

  // Operand magnitudes are taken at acceptance so CALC only sees unsigned values.
  always_comb begin
    a_signed  = op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    b_signed  = op_in inside {OP_MULH, OP_DIV, OP_REM};
    is_div_in = op_in inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    a_mag     = (a_signed && a[WIDTH-1]) ? -a : a;
    b_mag     = (b_signed && b[WIDTH-1]) ? -b : b;
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (in_valid)         state_d = S_CALC;
      S_CALC: if (count_q == LAST_CNT) state_d = S_FIX;
      S_FIX:                        state_d = S_DONE;
      S_DONE: if (out_ready)        state_d = S_IDLE;
      default:                      state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  // One iteration step: shift-add multiply or restoring divide.
  always_comb begin
    is_div_q  = op_q inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {acc_q, lo_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opnd_q});
    div_diff  = div_shift[WIDTH-1:0] - opnd_q;
    if (is_div_q) begin
      acc_d = div_ge ? div_diff : div_shift[WIDTH-1:0];
      lo_d  = {lo_q[WIDTH-2:0], div_ge};
    end else begin
      acc_d = mul_sum[WIDTH:1];
      lo_d  = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  // Sign correction and special cases, evaluated while in FIX.
  always_comb begin
    a_neg   = a_q[WIDTH-1];
    b_neg   = b_q[WIDTH-1];
    b_zero  = (b_q == '0);
    sgn_ovf = (a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (b_q == '1);
    // High half of the 2*WIDTH two's complement: the carry into it only
    // survives when the low half is all zeros.
    hi_neg  = ~acc_q + WIDTH'(lo_q == '0);
    quo_neg = -lo_q;
    rem_neg = -acc_q;
    unique case (op_q)
      OP_MUL:    fix_result = lo_q;
      OP_MULH:   fix_result = (a_neg ^ b_neg) ? hi_neg : acc_q;
      OP_MULHSU: fix_result = a_neg ? hi_neg : acc_q;
      OP_MULHU:  fix_result = acc_q;
      OP_DIV:    fix_result = b_zero  ? '1 :
                              sgn_ovf ? a_q :
                              (a_neg ^ b_neg) ? quo_neg : lo_q;
      OP_DIVU:   fix_result = b_zero ? '1 : lo_q;
      OP_REM:    fix_result = b_zero  ? a_q :
                              sgn_ovf ? '0 :
                              a_neg ? rem_neg : acc_q;
      OP_REMU:   fix_result = b_zero ? a_q : acc_q;
      default:   fix_result = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: all datapath registers, result included, are reset so the outputs
  // are deterministic straight out of reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q     <= OP_MUL;
      a_q      <= '0;
      b_q      <= '0;
      opnd_q   <= '0;
      acc_q    <= '0;
      lo_q     <= '0;
      count_q  <= '0;
      result_q <= '0;
    end else if (accept) begin
      op_q    <= op_in;
      a_q     <= a;
      b_q     <= b;
      opnd_q  <= is_div_in ? b_mag : a_mag;
      lo_q    <= is_div_in ? a_mag : b_mag;
      acc_q   <= '0;
      count_q <= '0;
    end else if (state_q == S_CALC && !flush) begin
      acc_q   <= acc_d;
      lo_q    <= lo_d;
      count_q <= count_q + CNT_W'(1);
    end else if (state_q == S_FIX && !flush) begin
      result_q <= fix_result;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, handshake/flush/reset
// sequences, and randomized operations against an arithmetic reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = '0, b = '0;
  logic        out_ready = 1'b0;
  logic        iv32 = 1'b0, iv8 = 1'b0;
  logic        ir32, ir8, ov32, ov8, busy32, busy8;
  logic [31:0] res32;
  logic [7:0]  res8;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32)) dut32 (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(iv32), .in_ready(ir32),
    .op(op), .a(a), .b(b), .out_valid(ov32), .out_ready(out_ready),
    .result(res32), .busy(busy32)
  );

  muldiv_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(iv8), .in_ready(ir8),
    .op(op), .a(a[7:0]), .b(b[7:0]), .out_valid(ov8), .out_ready(out_ready),
    .result(res8), .busy(busy8)
  );

  typedef struct {
    bit          w8;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic add(input bit w8, input logic [2:0] o, input logic [31:0] ai,
                     input logic [31:0] bi, input logic [31:0] e, input string name);
    vec_t v;
    v.w8 = w8; v.op = o; v.a = ai; v.b = bi; v.exp = e; v.name = name;
    vecs.push_back(v);
  endtask

  // Reference: plain 64-bit arithmetic on sign- or zero-extended operands.
  function automatic logic [31:0] model(input int w, input logic [2:0] o,
                                        input logic [31:0] ai, input logic [31:0] bi);
    logic [63:0] mask, ua, ub, sa, sb, p;
    longint      ssa, ssb, q;
    mask = (64'd1 << w) - 64'd1;
    ua   = {32'd0, ai} & mask;
    ub   = {32'd0, bi} & mask;
    sa   = ai[w-1] ? (ua | ~mask) : ua;
    sb   = bi[w-1] ? (ub | ~mask) : ub;
    ssa  = signed'(sa);
    ssb  = signed'(sb);
    p    = '0;
    case (o)
      3'd0: p = ua * ub;
      3'd1: p = (sa * sb) >> w;
      3'd2: p = (sa * ub) >> w;
      3'd3: p = (ua * ub) >> w;
      3'd4: begin
        if (ub == 0) p = mask;
        else if (ssa == -(longint'(1) << (w - 1)) && ssb == -1) p = ua;
        else begin q = ssa / ssb; p = q; end
      end
      3'd5: p = (ub == 0) ? mask : ua / ub;
      3'd6: begin
        if (ub == 0) p = ua;
        else if (ssa == -(longint'(1) << (w - 1)) && ssb == -1) p = 0;
        else begin q = ssa % ssb; p = q; end
      end
      default: p = (ub == 0) ? ua : ua % ub;
    endcase
    return 32'(p & mask);
  endfunction

  function automatic logic cur_valid(input bit w8);
    return w8 ? ov8 : ov32;
  endfunction

  function automatic logic cur_ready(input bit w8);
    return w8 ? ir8 : ir32;
  endfunction

  function automatic logic [31:0] cur_res(input bit w8);
    return w8 ? {24'd0, res8} : res32;
  endfunction

  // Issue one op, scramble inputs after acceptance, measure latency, optionally
  // stall the consumer for `hold` cycles, then complete the output handshake.
  task automatic run_op(input bit w8, input logic [2:0] o, input logic [31:0] ai,
                        input logic [31:0] bi, input int hold, input string name,
                        output logic [31:0] res);
    int lat;
    check({name, " in_ready_pre"}, 32'(cur_ready(w8)), 32'd1);
    op = o; a = ai; b = bi;
    if (w8) iv8 = 1'b1; else iv32 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0; iv32 = 1'b0;
    op = 3'($urandom); a = $urandom; b = $urandom;
    lat = 0;
    while (!cur_valid(w8) && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, " latency"}, 32'(lat), w8 ? 32'd9 : 32'd33);
    res = cur_res(w8);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({name, " hold_result"}, cur_res(w8), res);
      check({name, " hold_ready"}, {cur_valid(w8), cur_ready(w8)}, 32'd2);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({name, " post_handshake"}, {cur_valid(w8), cur_ready(w8)}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] r, ra, rb;
    logic [2:0]  ro;
    bit          seen;
    int          lat;

    add(0, 3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, "mul_m1");
    add(0, 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, "mulh_m1");
    add(0, 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu_m1");
    add(0, 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulhsu_m1");
    add(0, 3'd1, 32'h80000000, 32'h80000000, 32'h40000000, "mulh_min");
    add(0, 3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, "div_m7_2");
    add(0, 3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, "rem_m7_2");
    add(0, 3'd5, 32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC, "divu_m7_2");
    add(0, 3'd7, 32'hFFFFFFF9, 32'd2,        32'h00000001, "remu_m7_2");
    add(0, 3'd4, 32'd20,       32'd6,        32'd3,        "div_20_6");
    add(0, 3'd6, 32'd20,       32'd6,        32'd2,        "rem_20_6");
    add(0, 3'd5, 32'd7,        32'd0,        32'hFFFFFFFF, "divu_by0");
    add(0, 3'd7, 32'd7,        32'd0,        32'd7,        "remu_by0");
    add(0, 3'd4, 32'hFFFFFFFF, 32'd0,        32'hFFFFFFFF, "div_by0");
    add(0, 3'd6, 32'hFFFFFFFF, 32'd0,        32'hFFFFFFFF, "rem_by0");
    add(0, 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, "div_ovf");
    add(0, 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, "rem_ovf");
    add(1, 3'd4, 32'hF9,       32'h02,       32'hFD,       "w8_div");
    add(1, 3'd6, 32'hF9,       32'h02,       32'hFF,       "w8_rem");
    add(1, 3'd0, 32'hFF,       32'hFF,       32'h01,       "w8_mul");
    add(1, 3'd3, 32'hFF,       32'hFF,       32'hFE,       "w8_mulhu");
    add(1, 3'd1, 32'h80,       32'h80,       32'h40,       "w8_mulh");
    add(1, 3'd4, 32'h80,       32'hFF,       32'h80,       "w8_div_ovf");
    add(1, 3'd6, 32'h80,       32'hFF,       32'h00,       "w8_rem_ovf");
    add(1, 3'd5, 32'h07,       32'h00,       32'hFF,       "w8_divu_by0");
    add(1, 3'd7, 32'h07,       32'h00,       32'h07,       "w8_remu_by0");

    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    check("reset_state32", {ir32, ov32, busy32}, 32'b100);
    check("reset_result32", res32, 32'd0);
    check("reset_state8", {24'd0, res8}, 32'd0);

    foreach (vecs[i]) begin
      run_op(vecs[i].w8, vecs[i].op, vecs[i].a, vecs[i].b, 0, vecs[i].name, r);
      check(vecs[i].name, r, vecs[i].exp);
    end

    // Consumer back-pressure for 5 cycles.
    run_op(0, 3'd4, 32'd100, 32'd7, 5, "hold5", r);
    check("hold5", r, 32'd14);

    // Reset in the middle of CALC.
    op = 3'd5; a = 32'd1000; b = 32'd3; iv32 = 1'b1;
    @(posedge clk); #1 iv32 = 1'b0;
    repeat (5) @(posedge clk);
    #1 reset_n = 1'b0;
    #2 reset_n = 1'b1;
    check("midreset_state", {ir32, ov32, busy32}, 32'b100);
    check("midreset_result", res32, 32'd0);
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1 seen |= ov32; end
    check("midreset_no_valid", 32'(seen), 32'd0);
    run_op(0, 3'd5, 32'd1000, 32'd3, 0, "after_reset", r);
    check("after_reset", r, 32'd333);

    // Flush at count=10 inside CALC.
    op = 3'd0; a = 32'd5; b = 32'd6; iv32 = 1'b1;
    @(posedge clk); #1 iv32 = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    check("flush_calc_state", {ir32, busy32}, 32'b10);
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1 seen |= ov32; end
    check("flush_calc_no_valid", 32'(seen), 32'd0);

    // Flush while the result is waiting in DONE.
    op = 3'd0; a = 32'd5; b = 32'd6; iv32 = 1'b1;
    @(posedge clk); #1 iv32 = 1'b0;
    lat = 0;
    while (!ov32 && lat < 200) begin @(posedge clk); #1 lat++; end
    check("flush_done_reached", 32'(ov32), 32'd1);
    check("flush_done_result", res32, 32'd30);
    flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    check("flush_done_state", {ir32, ov32, busy32}, 32'b100);

    // Flush together with a request in IDLE must not accept it.
    op = 3'd0; a = 32'd2; b = 32'd3; iv32 = 1'b1; flush = 1'b1;
    @(posedge clk); #1 iv32 = 1'b0; flush = 1'b0;
    check("flush_idle_reject", {ir32, busy32}, 32'b10);
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1 seen |= ov32 | busy32; end
    check("flush_idle_quiet", 32'(seen), 32'd0);

    // Randomized operations at both widths, biased toward the special cases.
    for (int n = 0; n < 120; n++) begin
      bit w8;
      w8 = n[0];
      ro = 3'($urandom);
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: begin ra = w8 ? 32'h80 : 32'h80000000; rb = '1; end
        2: rb = $urandom_range(1, 5);
        default: ;
      endcase
      if (w8) begin ra = ra & 32'hFF; rb = rb & 32'hFF; end
      run_op(w8, ro, ra, rb, 0, "rand", r);
      check("rand", r, model(w8 ? 8 : 32, ro, ra, rb));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
